int_controller: RTL
===================

# int_controller

Interrupt controller sitting between external interrupt lines and the core FSM. It synchronises and edge-detects the raw request lines and latches them as pending. It arbitrates by fixed priority and drives the FSM `ext_int`/`sw_int` inputs. It tracks a single in-service source through a take/complete handshake so that external interrupts do not nest.

## Interface
- `NUM_SOURCES`, default 4: number of external interrupt lines, range 2..16.
- `ID_BITS`, default `$clog2(NUM_SOURCES)`: width of source ids.

- `clk`  in  1  core clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset; clears all state immediately.
- `irq`  in  NUM_SOURCES  raw request lines, asynchronous to `clk`; rising edge requests service.
- `enable_we`  in  1  write strobe for the enable mask.
- `enable_wdata`  in  NUM_SOURCES  new enable mask.
- `sw_set`  in  1  set software-interrupt pending.
- `sw_clear`  in  1  clear software-interrupt pending.
- `take_int`  in  1  one-cycle pulse from core: control stage committed to an external interrupt.
- `complete`  in  1  one-cycle pulse: handler finished.
- `complete_id`  in  ID_BITS  id being completed.
- `ext_int`  out  1  to FSM: an enabled external interrupt awaits service.
- `sw_int`  out  1  to FSM: software interrupt pending.
- `busy`  out  1  a source is in service.
- `claim_id`  out  ID_BITS  id of the in-service source; meaningful only while `busy`.
- `pending`  out  NUM_SOURCES  raw pending bits, for CSR readback.
- `enable`  out  NUM_SOURCES  current enable mask.

## Operation
- Each `irq[i]` passes through a 2-flop synchroniser (`s1`, `s2`) and then a history flop `h`. `edge[i] = s2 & ~h`.
- Pending update: `pending[i]` next = `edge[i] | (pending[i] & ~claim_hit[i])`. A new edge wins over a same-cycle clear by claim. Repeated edges while pending coalesce into one.
- Pending latches regardless of the enable mask. A disabled pending bit stays set and fires once it is enabled.
- `enable` loads `enable_wdata` when `enable_we`=1; otherwise it holds.
- Arbitration: `req = pending & enable`. The selected source is the lowest set index in `req`; index 0 has highest priority.
- `ext_int = |req & ~busy`. This is combinational from registered state only, so it is glitch-free.
- Controller states: IDLE (`busy`=0) and IN_SERVICE (`busy`=1).
  - IDLE -> IN_SERVICE on `take_int` & `ext_int`. On that transition, `claim_id` is set to the selected id and `claim_hit[selected]`=1 clears its pending bit.
  - `take_int` while `ext_int`=0 is ignored, with no state change.
  - IN_SERVICE -> IDLE on `complete` & (`complete_id == claim_id`).
  - `complete` with a mismatched id, or while IDLE, is ignored.
- Same-cycle `complete` and `take_int`: `ext_int` is evaluated on pre-edge state, where `busy`=1, so `take_int` is ignored and only the complete takes effect.
- A source may re-pend while it is itself in service. It is serviced again after its completion.
- Software interrupt:
  - `sw_pending` is set by `sw_set` and cleared by `sw_clear`; `sw_set` wins if both are asserted.
  - `sw_int = sw_pending`. It is independent of `busy`; the FSM gives `ext_int` priority.

## Timing
- Reset values: `ext_int`=0, `sw_int`=0, `busy`=0, `claim_id`=0, `pending`=0, `enable`=0, all synchroniser and history flops 0. Reset asserted mid-service drops `busy` and all pending bits at once.
- `irq` latency: `irq[i]` rises before edge E1. `s1`=1 after E1, `s2`=1 after E2, `pending[i]`=1 after E3. `ext_int` rises after E3 if the source is enabled and `busy`=0.
- A pulse on `irq` shorter than one clock period may be lost. Sources must hold the request at least 2 cycles.
- `take_int` at edge E: `busy`=1, `claim_id` valid and `ext_int`=0 after E.
- `complete` at edge E: `busy`=0 after E. If another request is pending, `ext_int` rises in the same cycle after E, which is zero-cycle re-arm.
- An enable write at edge E affects `ext_int` after E.
- `sw_set` at E gives `sw_int`=1 after E.

## Test plan
- Reset, then `enable`=4'b1111 and `irq[2]` raised -> `pending`=4'b0100 and `ext_int`=1 exactly 3 edges after the first sample. `take_int` -> `busy`=1, `claim_id`=2, `pending`=0, `ext_int`=0.
- `irq[1]` and `irq[3]` rise together -> `take_int` claims id 1. `complete` with id 3 is ignored (`busy` stays 1). `complete` with id 1 -> `ext_int`=1 in the next cycle, and the next `take_int` claims 3.
- `enable`=0 and `irq[0]` rises -> `pending[0]`=1, `ext_int`=0. Writing `enable`=4'b0001 -> `ext_int`=1 in the next cycle. `take_int` while `ext_int`=0 -> no state change.
- `irq[0]` re-edges in the same cycle as its claim -> `busy`=1, `claim_id`=0, `pending[0]`=1. `complete` with id 0 -> `ext_int`=1 again.
- `sw_set` and `sw_clear` in the same cycle -> `sw_int`=1. `sw_clear` alone -> `sw_int`=0. `complete` and `take_int` in the same cycle while busy -> `busy`=0 and no new claim.
- Assert `reset` asynchronously mid-service with pending bits set -> all outputs return to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/int_controller.sv
// int_controller
// ----------------------------------------------------------------------------
// Interrupt controller between raw external request lines and the core FSM.
// Each request line is synchronised, rising-edge detected and latched as
// pending. Pending and enabled sources are arbitrated by fixed priority
// (index 0 highest). A single source is tracked in service through a
// take/complete handshake, so external interrupts never nest. A separate
// software-interrupt pending flag is also kept here.
//
// Ports:
//   clk           core clock, all state changes on its rising edge
//   reset         asynchronous active-high reset, clears all state
//   irq           raw request lines (asynchronous), rising edge requests service
//   enable_we     write strobe for the enable mask
//   enable_wdata  new enable mask
//   sw_set        set software-interrupt pending (wins over sw_clear)
//   sw_clear      clear software-interrupt pending
//   take_int      core committed to the external interrupt (1-cycle pulse)
//   complete      handler finished (1-cycle pulse)
//   complete_id   id being completed
//   ext_int       an enabled external interrupt awaits service
//   sw_int        software interrupt pending
//   busy          a source is in service
//   claim_id      id of the in-service source (meaningful while busy)
//   pending       raw pending bits for CSR readback
//   enable        current enable mask
// ----------------------------------------------------------------------------
module int_controller #(
   parameter int NUM_SOURCES = 4,
   parameter int ID_BITS     = $clog2(NUM_SOURCES)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SOURCES-1:0] irq,
   input  logic                   enable_we,
   input  logic [NUM_SOURCES-1:0] enable_wdata,
   input  logic                   sw_set,
   input  logic                   sw_clear,
   input  logic                   take_int,
   input  logic                   complete,
   input  logic [ID_BITS-1:0]     complete_id,
   output logic                   ext_int,
   output logic                   sw_int,
   output logic                   busy,
   output logic [ID_BITS-1:0]     claim_id,
   output logic [NUM_SOURCES-1:0] pending,
   output logic [NUM_SOURCES-1:0] enable
);

   typedef enum logic {
      IDLE       = 1'b0,
      IN_SERVICE = 1'b1
   } state_t;

   logic [NUM_SOURCES-1:0] s1_r;
   logic [NUM_SOURCES-1:0] s2_r;
   logic [NUM_SOURCES-1:0] h_r;
   logic [NUM_SOURCES-1:0] pending_r;
   logic [NUM_SOURCES-1:0] enable_r;
   logic [ID_BITS-1:0]     claim_id_r;
   logic                   sw_pending_r;
   state_t                 state_r;

   logic [NUM_SOURCES-1:0] edge_s;
   logic [NUM_SOURCES-1:0] req_s;
   logic [NUM_SOURCES-1:0] claim_hit_s;
   logic [ID_BITS-1:0]     sel_id_s;
   logic [ID_BITS-1:0]     claim_id_nxt_s;
   logic                   ext_int_s;
   state_t                 state_nxt_s;

   assign edge_s    = s2_r & ~h_r;
   assign req_s     = pending_r & enable_r;
   // Built from registered state only, so the FSM sees a glitch-free level.
   assign ext_int_s = (|req_s) & (state_r == IDLE);

   // Synchroniser and edge-history flops for the raw request lines.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_r <= '0;
         s2_r <= '0;
         h_r  <= '0;
      end else begin
         s1_r <= irq;
         s2_r <= s1_r;
         h_r  <= s2_r;
      end
   end

   // Pending latch: a fresh edge wins over a same-cycle claim clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_r <= '0;
      end else begin
         pending_r <= edge_s | (pending_r & ~claim_hit_s);
      end
   end

   // Enable mask register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable_r <= '0;
      end else if (enable_we) begin
         enable_r <= enable_wdata;
      end else begin
         enable_r <= enable_r;
      end
   end

   // Software-interrupt pending flag; set has priority over clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_pending_r <= 1'b0;
      end else if (sw_set) begin
         sw_pending_r <= 1'b1;
      end else if (sw_clear) begin
         sw_pending_r <= 1'b0;
      end else begin
         sw_pending_r <= sw_pending_r;
      end
   end

   // Fixed-priority select: scan downward so the lowest set index ends up chosen.
   always_comb begin
      sel_id_s = '0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (req_s[i]) begin
            sel_id_s = ID_BITS'(i);
         end else begin
            sel_id_s = sel_id_s;
         end
      end
   end

   // Service FSM state and claim register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         claim_id_r <= '0;
      end else begin
         state_r    <= state_nxt_s;
         claim_id_r <= claim_id_nxt_s;
      end
   end

   // Service FSM next state, claim capture and pending clear on take.
   always_comb begin
      state_nxt_s    = state_r;
      claim_id_nxt_s = claim_id_r;
      claim_hit_s    = '0;
      case (state_r)
         IDLE: begin
            // ext_int_s already implies IDLE; a take without it is ignored.
            if (take_int && ext_int_s) begin
               state_nxt_s    = IN_SERVICE;
               claim_id_nxt_s = sel_id_s;
               claim_hit_s    = {{(NUM_SOURCES-1){1'b0}}, 1'b1} << sel_id_s;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         IN_SERVICE: begin
            // A take in the same cycle is dropped since ext_int_s is low here.
            if (complete && (complete_id == claim_id_r)) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = IN_SERVICE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   assign ext_int  = ext_int_s;
   assign sw_int   = sw_pending_r;
   assign busy     = (state_r == IN_SERVICE);
   assign claim_id = claim_id_r;
   assign pending  = pending_r;
   assign enable   = enable_r;

endmodule
